// File: rtl/escalonador_quantum_rr_if.sv
// Scheduler <-> CPU control bundle: retire/PC/event inputs and scheduling outputs.
// Latency: wiring only.
// Backpressure: none; every event is a single-cycle pulse sampled on the clock edge.
interface escalonador_quantum_rr_if #(
    parameter int NUM_PROC = 10,
    parameter int PID_W    = 4,
    parameter int PC_W     = 32
);
    logic                 enable;
    logic [PC_W-1:0]      pc;
    logic                 start;
    logic [PID_W-1:0]     proc_count;
    logic                 proc_end;
    logic                 io_block;
    logic                 io_done;
    logic [PID_W-1:0]     io_pid;

    logic                 ctx_switch;
    logic [PC_W-1:0]      switch_pc;
    logic [PID_W-1:0]     cur_pid;
    logic [PID_W-1:0]     next_pid;
    logic [NUM_PROC-1:0]  active_mask;
    logic [NUM_PROC-1:0]  wait_mask;
    logic                 pc_mismatch;
    logic                 cfg_err;
    logic                 all_done;

    // CPU side: drives retire/PC/events, observes scheduling decisions
    modport master (
        output enable, pc, start, proc_count, proc_end, io_block, io_done, io_pid,
        input  ctx_switch, switch_pc, cur_pid, next_pid, active_mask, wait_mask,
               pc_mismatch, cfg_err, all_done
    );

    // Scheduler side
    modport slave (
        input  enable, pc, start, proc_count, proc_end, io_block, io_done, io_pid,
        output ctx_switch, switch_pc, cur_pid, next_pid, active_mask, wait_mask,
               pc_mismatch, cfg_err, all_done
    );
endinterface

// File: rtl/escalonador_quantum_rr.sv
// Round-robin process scheduler with per-process active/blocked tracking and a retire-count quantum.
// Latency: ctx_switch asserted during the one-cycle SWITCH state; pc_mismatch and cfg_err are 1 cycle after their cause.
// Backpressure: none; events are single-cycle pulses and are never stalled.
module escalonador_quantum_rr #(
    parameter int NUM_PROC  = 10,
    parameter int PID_W     = 4,
    parameter int PC_W      = 32,
    parameter int QUANTUM   = 16,
    parameter int PROC_BASE = 300,
    parameter int PROC_SIZE = 300,
    parameter int SAVE_ADDR = 180
) (
    input logic                    clock_i,
    input logic                    reset_i,
    escalonador_quantum_rr_if.slave sched_if
);
    localparam int QCNT_W = $clog2(QUANTUM);
    localparam logic [QCNT_W-1:0] QMAX      = QCNT_W'(QUANTUM - 1);
    localparam logic [PID_W-1:0]  NUM_PID   = PID_W'(NUM_PROC);
    localparam logic [PC_W-1:0]   BASE_C    = PC_W'(PROC_BASE);
    localparam logic [PC_W-1:0]   SIZE_C    = PC_W'(PROC_SIZE);
    localparam logic [PC_W-1:0]   NUM_PC    = PC_W'(NUM_PROC);
    localparam logic [PC_W-1:0]   SAVE_C    = PC_W'(SAVE_ADDR);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_SWITCH, S_WAIT_IO, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [QCNT_W-1:0]    qcnt_q, qcnt_d;
    logic [PID_W-1:0]     cur_pid_q, cur_pid_d;
    logic [NUM_PROC-1:0]  active_q, active_d;
    logic [NUM_PROC-1:0]  wait_q, wait_d;
    logic                 all_done_q, all_done_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 mismatch_q, mismatch_d;
    logic [1:0]           blank_q, blank_d;

    logic [NUM_PROC-1:0]  ready;
    logic [NUM_PROC-1:0]  cur_oh;
    logic [NUM_PROC-1:0]  io_clr;
    logic                 cfg_ok;
    logic                 found_vld;
    logic [PID_W-1:0]     found_pid;
    logic [PC_W-1:0]      region_raw;
    logic [PID_W-1:0]     region_pid;

    // One-hot of a PID; PID 0 and PIDs beyond NUM_PROC decode to all zeros
    function automatic logic [NUM_PROC-1:0] pid_onehot(input logic [PID_W-1:0] pid);
        pid_onehot = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (pid == PID_W'(i + 1)) pid_onehot[i] = 1'b1;
        end
    endfunction

    assign ready  = active_q & ~wait_q;
    assign cur_oh = pid_onehot(cur_pid_q);
    assign cfg_ok = (sched_if.proc_count != '0) && (sched_if.proc_count <= NUM_PID);
    // io_done only touches live processes, and never before scheduling has started
    assign io_clr = (sched_if.io_done && state_q != S_IDLE) ? (pid_onehot(sched_if.io_pid) & active_q) : '0;

    // Round-robin search: first ready PID after cur_pid, wrapping; cur_pid itself is tried last
    always_comb begin
        int p;
        p         = 0;
        found_vld = 1'b0;
        found_pid = '0;
        for (int k = 1; k <= NUM_PROC; k++) begin
            p = int'(cur_pid_q) + k;
            if (p > NUM_PROC) p = p - NUM_PROC;
            if (!found_vld && ready[p-1]) begin
                found_vld = 1'b1;
                found_pid = PID_W'(p);
            end
        end
    end

    // Region PID of the current PC; regions past the last process map to the OS (0)
    always_comb begin
        region_raw = ((sched_if.pc - BASE_C) / SIZE_C) + PC_W'(1);
        region_pid = '0;
        if (sched_if.pc >= BASE_C && region_raw <= NUM_PC) region_pid = PID_W'(region_raw);
    end

    // FSM state register
    always_ff @(posedge clock_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (sched_if.start && cfg_ok) state_d = S_RUN;
            S_RUN: begin
                if (sched_if.proc_end || sched_if.io_block || (sched_if.enable && qcnt_q == QMAX))
                    state_d = S_SWITCH;
            end
            S_SWITCH: begin
                if (ready != '0)       state_d = S_RUN;
                else if (wait_q != '0) state_d = S_WAIT_IO;
                else                   state_d = S_DONE;
            end
            S_WAIT_IO: if (ready != '0) state_d = S_SWITCH;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: the switch request is only raised when a different PID takes over
    always_comb begin
        sched_if.ctx_switch = 1'b0;
        sched_if.next_pid   = '0;
        sched_if.switch_pc  = '0;
        if (state_q == S_SWITCH && found_vld && found_pid != cur_pid_q) begin
            sched_if.ctx_switch = 1'b1;
            sched_if.next_pid   = found_pid;
            sched_if.switch_pc  = SAVE_C;
        end
    end

    // Datapath next state: masks, quantum counter, running PID, status flags
    always_comb begin
        active_d   = active_q;
        wait_d     = wait_q & ~io_clr;
        cur_pid_d  = cur_pid_q;
        qcnt_d     = qcnt_q;
        all_done_d = all_done_q;
        cfg_err_d  = 1'b0;
        blank_d    = (blank_q != 2'd0) ? blank_q - 2'd1 : 2'd0;
        mismatch_d = (state_q == S_RUN) && (blank_q == 2'd0) && (region_pid != cur_pid_q);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (sched_if.start) begin
                    if (cfg_ok) begin
                        for (int i = 0; i < NUM_PROC; i++)
                            active_d[i] = (PID_W'(i) < sched_if.proc_count);
                        wait_d     = '0;
                        cur_pid_d  = PID_W'(1);
                        qcnt_d     = '0;
                        all_done_d = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (sched_if.proc_end) begin
                    active_d = active_q & ~cur_oh;
                    qcnt_d   = '0;
                end else if (sched_if.io_block) begin
                    // applied after the io_done clear so a same-cycle block wins
                    wait_d = wait_d | cur_oh;
                    qcnt_d = '0;
                end else if (sched_if.enable) begin
                    qcnt_d = (qcnt_q == QMAX) ? '0 : qcnt_q + QCNT_W'(1);
                end
            end
            S_SWITCH: begin
                qcnt_d  = '0;
                blank_d = 2'd2;
                if (ready != '0) begin
                    cur_pid_d = found_pid;
                end else begin
                    cur_pid_d = '0;
                    if (wait_q == '0) all_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            qcnt_q     <= '0;
            cur_pid_q  <= '0;
            active_q   <= '0;
            wait_q     <= '0;
            all_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            mismatch_q <= 1'b0;
            blank_q    <= 2'd0;
        end else begin
            qcnt_q     <= qcnt_d;
            cur_pid_q  <= cur_pid_d;
            active_q   <= active_d;
            wait_q     <= wait_d;
            all_done_q <= all_done_d;
            cfg_err_q  <= cfg_err_d;
            mismatch_q <= mismatch_d;
            blank_q    <= blank_d;
        end
    end

    assign sched_if.cur_pid     = cur_pid_q;
    assign sched_if.active_mask = active_q;
    assign sched_if.wait_mask   = wait_q;
    assign sched_if.pc_mismatch = mismatch_q;
    assign sched_if.cfg_err     = cfg_err_q;
    assign sched_if.all_done    = all_done_q;
endmodule

// File: tb/tb_escalonador_quantum_rr.sv
module tb_escalonador_quantum_rr;
    localparam int NUM_PROC = 10;
    localparam int PID_W    = 4;
    localparam int PC_W     = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    escalonador_quantum_rr_if #(.NUM_PROC(NUM_PROC), .PID_W(PID_W), .PC_W(PC_W)) bus ();

    escalonador_quantum_rr #(
        .NUM_PROC(NUM_PROC), .PID_W(PID_W), .PC_W(PC_W),
        .QUANTUM(16), .PROC_BASE(300), .PROC_SIZE(300), .SAVE_ADDR(180)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .sched_if(bus)
    );

    typedef struct { logic [PID_W-1:0] pid; int cyc; } sb_t;
    typedef struct { int count; logic exp_err; } cfg_vec_t;
    typedef struct { int pc; logic exp_mm; } pc_vec_t;

    sb_t sb_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle; every context switch the DUT raises is matched against the scoreboard
    task automatic tick();
        sb_t e;
        @(negedge clk);
        cyc++;
        if (bus.ctx_switch === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ctx_switch: got next_pid=%0d expected no switch (cycle %0d)", bus.next_pid, cyc);
            end else begin
                e = sb_q.pop_front();
                check("next_pid", 32'(bus.next_pid), 32'(e.pid));
                check("switch_pc", bus.switch_pc, 32'd180);
                if (e.cyc >= 0) check("switch_cycle", cyc, e.cyc);
            end
        end
    endtask

    task automatic push_sw(input int pid, input int at_cyc);
        sb_t e;
        e.pid = PID_W'(pid);
        e.cyc = at_cyc;
        sb_q.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.enable = 1'b0; bus.pc = 32'd300; bus.start = 1'b0; bus.proc_count = '0;
        bus.proc_end = 1'b0; bus.io_block = 1'b0; bus.io_done = 1'b0; bus.io_pid = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctx_switch"}, 32'(bus.ctx_switch), 0);
        check({tag, "_switch_pc"}, bus.switch_pc, 0);
        check({tag, "_cur_pid"}, 32'(bus.cur_pid), 0);
        check({tag, "_next_pid"}, 32'(bus.next_pid), 0);
        check({tag, "_active"}, 32'(bus.active_mask), 0);
        check({tag, "_wait"}, 32'(bus.wait_mask), 0);
        check({tag, "_pc_mismatch"}, 32'(bus.pc_mismatch), 0);
        check({tag, "_cfg_err"}, 32'(bus.cfg_err), 0);
        check({tag, "_all_done"}, 32'(bus.all_done), 0);
    endtask

    task automatic do_reset();
        check("scoreboard_drained", sb_q.size(), 0);
        sb_q.delete();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start_proc(input int count);
        bus.start      = 1'b1;
        bus.proc_count = PID_W'(count);
        tick();
        bus.start      = 1'b0;
    endtask

    cfg_vec_t cfg_tab[3];
    pc_vec_t  pc_tab[8];

    initial begin
        int c0;
        int n;
        cfg_tab[0] = '{0, 1'b1};
        cfg_tab[1] = '{11, 1'b1};
        cfg_tab[2] = '{15, 1'b1};
        pc_tab[0] = '{0, 1'b1};
        pc_tab[1] = '{299, 1'b1};
        pc_tab[2] = '{300, 1'b0};
        pc_tab[3] = '{599, 1'b0};
        pc_tab[4] = '{600, 1'b1};
        pc_tab[5] = '{650, 1'b1};
        pc_tab[6] = '{3299, 1'b1};
        pc_tab[7] = '{3300, 1'b1};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        check_zero("idle");

        // Pure quantum rotation over 3 processes, then reset while in SWITCH
        bus.enable = 1'b1;
        c0 = cyc;
        push_sw(2, c0 + 17);
        push_sw(3, c0 + 34);
        push_sw(1, c0 + 51);
        push_sw(2, c0 + 68);
        start_proc(3);
        check("q_cur_pid_start", 32'(bus.cur_pid), 1);
        check("q_active", 32'(bus.active_mask), 32'b111);
        repeat (17) tick();
        check("q_cur_pid_after", 32'(bus.cur_pid), 2);
        while (cyc < c0 + 68) tick();
        rst = 1'b1;
        bus.enable = 1'b0;
        tick();
        check_zero("reset_mid_switch");
        rst = 1'b0;

        // proc_end path down to DONE, then a bad start from DONE
        do_reset();
        start_proc(2);
        bus.proc_end = 1'b1;
        push_sw(2, -1);
        tick();
        bus.proc_end = 1'b0;
        check("end_active_10", 32'(bus.active_mask), 32'b10);
        tick();
        check("end_cur_pid_2", 32'(bus.cur_pid), 2);
        bus.proc_end = 1'b1;
        tick();
        bus.proc_end = 1'b0;
        check("end_active_0", 32'(bus.active_mask), 0);
        tick();
        check("end_all_done", 32'(bus.all_done), 1);
        check("end_cur_pid_0", 32'(bus.cur_pid), 0);
        start_proc(0);
        check("done_cfg_err", 32'(bus.cfg_err), 1);
        tick();
        check("done_cfg_err_pulse", 32'(bus.cfg_err), 0);
        check("done_all_done_held", 32'(bus.all_done), 1);

        // IN blocking, WAIT_IO, ignored io_done, resume, same-cycle block/done
        do_reset();
        start_proc(2);
        bus.io_block = 1'b1;
        push_sw(2, -1);
        tick();
        bus.io_block = 1'b0;
        check("io_wait_01", 32'(bus.wait_mask), 32'b01);
        tick();
        check("io_cur_pid_2", 32'(bus.cur_pid), 2);
        bus.io_block = 1'b1;
        tick();
        bus.io_block = 1'b0;
        tick();
        check("io_waitio_cur_pid", 32'(bus.cur_pid), 0);
        check("io_wait_11", 32'(bus.wait_mask), 32'b11);
        bus.io_done = 1'b1;
        bus.io_pid  = 4'd0;
        tick();
        bus.io_pid  = 4'd11;
        tick();
        bus.io_done = 1'b0;
        tick();
        check("io_bad_pid_ignored", 32'(bus.wait_mask), 32'b11);
        bus.io_done = 1'b1;
        bus.io_pid  = 4'd2;
        push_sw(2, -1);
        tick();
        bus.io_done = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 6) begin
            tick();
            n++;
        end
        check("io_resume_pending", sb_q.size(), 0);
        tick();
        check("io_resumed_cur_pid", 32'(bus.cur_pid), 2);
        check("io_resumed_wait", 32'(bus.wait_mask), 32'b01);
        bus.io_block = 1'b1;
        bus.io_done  = 1'b1;
        bus.io_pid   = 4'd2;
        tick();
        bus.io_block = 1'b0;
        bus.io_done  = 1'b0;
        check("io_block_wins", 32'(bus.wait_mask), 32'b11);
        tick();
        check("io_block_wins_waitio", 32'(bus.cur_pid), 0);

        // Single process: quantum expiry never produces a switch
        do_reset();
        start_proc(1);
        bus.enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check($sformatf("solo_cur_pid_%0d", i), 32'(bus.cur_pid), 1);
        end
        bus.enable = 1'b0;

        // Bad proc_count table from IDLE
        do_reset();
        for (int i = 0; i < 3; i++) begin
            start_proc(cfg_tab[i].count);
            check($sformatf("cfg_err_%0d", cfg_tab[i].count), 32'(bus.cfg_err), 32'(cfg_tab[i].exp_err));
            tick();
            check($sformatf("cfg_err_pulse_%0d", cfg_tab[i].count), 32'(bus.cfg_err), 0);
            check($sformatf("cfg_stays_idle_%0d", cfg_tab[i].count), 32'(bus.cur_pid), 0);
        end

        // Region PID vs cur_pid=1 table
        do_reset();
        start_proc(3);
        for (int i = 0; i < 8; i++) begin
            bus.pc = pc_tab[i].pc;
            tick();
            check($sformatf("pc_mismatch_pc%0d", pc_tab[i].pc), 32'(bus.pc_mismatch), 32'(pc_tab[i].exp_mm));
        end
        bus.pc = 32'd300;

        check("final_scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
